scazator_16bit_pipe: RTL and testbench
======================================

# scazator_16bit_pipe

Pipelined 16-bit subtractor computing `a - b - bin` with valid/ready handshakes on both sides, the inverse-direction companion to the 16-bit carry-lookahead adder. The operation is split across two register stages of 8 bits each, with borrow rippled between them. Throughput is one operation per cycle and latency is two cycles. It sits between operand sources and result consumers in the datapath, and reports borrow-out, signed overflow and zero for each result.

## Interface
- No parameters; width fixed at 16 bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block can accept operands this cycle.
- `a`  in  16  minuend.
- `b`  in  16  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result registers hold a valid result.
- `out_ready`  in  1  consumer accepts result this cycle.
- `diff`  out  16  `a - b - bin` (mod 2^16, or saturated, see Configuration).
- `bout`  out  1  unsigned borrow-out; 1 iff `a < b + bin`.
- `ovf`  out  1  signed (two's complement) overflow.
- `zero`  out  1  `diff == 16'h0000` (after saturation, if enabled).

## Operation
- Arithmetic: `a + ~b + !bin`.
  - Carry-in is `!bin`; `bout = !c16`.
  - `ovf = c15 ^ c16`, where c15 is the carry into bit 15 and c16 the carry out of bit 15.
- Stage 1 (S1):
  - On accept, computes `diff[7:0]` and c8 using an 8-bit lookahead (group P/G per nibble).
  - Registers `diff[7:0]`, c8, `a[15:8]` and `b[15:8]`.
  - Sets `s1_valid`.
- Stage 2 (S2, output registers):
  - Computes `diff[15:8]`, c15 and c16 from the registered upper bytes and c8.
  - Registers `diff`, `bout`, `ovf` and `zero`, and sets `out_valid`.
- Handshake:
  - Input transfer when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
  - `s2_en = !out_valid || out_ready`.
  - `in_ready = !s1_valid || s2_en`, combinational from state and `out_ready` only. No dependence on `in_valid`.
- Stage advance:
  - S1 moves to S2 when `s1_valid && s2_en`.
  - S1 loads on input transfer.
  - S1 clears when it advances with no new input.
  - S2 clears `out_valid` on output transfer when S1 is empty.
- Stall behaviour:
  - While `out_valid && !out_ready`, `diff`, `bout`, `ovf` and `zero` hold stable.
  - S1 holds its contents.
- No operand is dropped or duplicated. Results appear in acceptance order.
- Simultaneous output transfer, S1 advance and input transfer in one cycle is legal and sustains full rate.
- Inputs are sampled only on input transfer. Values when `in_valid=0` are ignored.

## Timing
- Reset (`rst_n=0` at a rising edge):
  - `out_valid=0`, `s1_valid=0`, `diff=16'h0000`, `bout=0`, `ovf=0`, `zero=0`.
  - `in_ready` reads 1 from the first cycle after reset.
- Reset mid-stream discards all in-flight operations. No result is emitted for them.
- Latency: operands accepted at edge k produce `out_valid=1` after edge k+1, with no stalls.
- Throughput: 1 result per cycle while `out_ready=1`.
- Capacity: 2 in-flight operations. With `out_ready` held low, `in_ready` falls after two accepts.
- `in_ready` rises in the same cycle that `out_ready` is asserted (combinational path).
- Critical path: one 8-bit lookahead plus register per stage.

## Configuration
- `SCAZATOR_SAT_EN` defined:
  - On `ovf=1`, `diff` is forced to `16'h7FFF` when `a[15]=0` (positive result), or to `16'h8000` when `a[15]=1`.
  - `zero` is computed on the saturated value.
  - `bout` and `ovf` are unchanged.
- Undefined: `diff` is the wrapped modulo-2^16 result. No saturation logic is compiled.

## Test plan
- Basic case: `a=16'h0005, b=16'h0003, bin=0` -> after 2 cycles `diff=16'h0002`, `bout=0`, `ovf=0`, `zero=0`.
- Borrow and zero:
  - `a=16'h0000, b=16'h0001, bin=0` -> `diff=16'hFFFF`, `bout=1`, `ovf=0`.
  - `a=16'h1234, b=16'h1233, bin=1` -> `diff=16'h0000`, `zero=1`, `bout=0`.
- Overflow via borrow-in: `a=16'h8000, b=16'h0000, bin=1` -> `ovf=1`, `bout=0`.
  - `diff=16'h7FFF` without the macro.
  - `diff=16'h8000` with `SCAZATOR_SAT_EN`.
- Positive overflow: `a=16'h7FFF, b=16'hFFFF, bin=0` -> `ovf=1`, `bout=1`.
  - `diff=16'h8000` without the macro.
  - `diff=16'h7FFF` with `SCAZATOR_SAT_EN`.
- Backpressure: stream 6 random operand sets with `in_valid=1` and `out_ready=0` for 5 cycles, then 1.
  - `in_ready` drops after 2 accepts.
  - Outputs stay stable while stalled.
  - All 6 results match a reference model, in order.
  - Full rate is sustained once `out_ready=1`.
- Reset mid-stream: assert `rst_n=0` for 1 cycle with 2 operations in flight.
  - Next cycle: `out_valid=0`, `diff=0`, `in_ready=1`.
  - No stale result appears afterwards.

Source files
------------

// File: rtl/scazator_16bit_pipe.sv
// scazator_16bit_pipe: two-stage pipelined 16-bit subtractor, diff = a - b - bin.
// The low byte is resolved in stage 1 and the high byte in stage 2, with the
// byte carry c8 registered between them. Valid/ready handshakes on both sides
// give one result per cycle and two cycles of latency.
// Optional build macro: SCAZATOR_SAT_EN clamps diff to 16'h7FFF / 16'h8000 on
// signed overflow; without it diff wraps modulo 2^16.
module scazator_16bit_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero
);

  // Result of one 8-bit lookahead slice: sum plus the carries into bit 7 and out of bit 7.
  typedef struct packed {
    logic [7:0] sum;
    logic       c7;
    logic       c8;
  } add8_t;

  // 8-bit adder with nibble group propagate/generate lookahead for c4 and c8.
  function automatic add8_t add8(input logic [7:0] x, input logic [7:0] y,
                                 input logic cin);
    logic [7:0] p;
    logic [7:0] g;
    logic [1:0] gp;
    logic [1:0] gg;
    logic [8:0] c;
    add8_t      r;
    p = x ^ y;
    g = x & y;
    for (int n = 0; n < 2; n++) begin
      gp[n] = &p[4*n +: 4];
      gg[n] = g[4*n+3]
            | (p[4*n+3] & g[4*n+2])
            | (p[4*n+3] & p[4*n+2] & g[4*n+1])
            | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
    end
    c    = '0;
    c[0] = cin;
    c[4] = gg[0] | (gp[0] & cin);
    c[8] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    // Bit carries inside each nibble start from that nibble's lookahead carry.
    for (int i = 0; i < 8; i++) begin
      if ((i % 4) != 3) c[i+1] = g[i] | (p[i] & c[i]);
    end
    r.sum = p ^ c[7:0];
    r.c7  = c[7];
    r.c8  = c[8];
    return r;
  endfunction

  // Stage 1 state
  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_lo_q;
  logic       s1_c8_q;
  logic [7:0] s1_ahi_q;
  logic [7:0] s1_bhi_q;

  // Stage 2 / output state
  logic        out_valid_q, out_valid_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  logic  s2_en;
  logic  in_xfer;
  add8_t s1_res;
  add8_t s2_res;
  logic  unused_s1_c7;

  assign s2_en    = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_en;
  assign in_xfer  = in_valid && in_ready;

  // Subtraction as a + ~b + !bin; the low byte carry c8 crosses the stage boundary.
  assign s1_res       = add8(a[7:0], ~b[7:0], ~bin);
  assign s2_res       = add8(s1_ahi_q, ~s1_bhi_q, s1_c8_q);
  assign unused_s1_c7 = s1_res.c7;

  // Next-state for both valid flags and the stage 2 result.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    diff_d      = {s2_res.sum, s1_lo_q};
    bout_d      = !s2_res.c8;
    ovf_d       = s2_res.c7 ^ s2_res.c8;

    if (in_xfer)                      s1_valid_d = 1'b1;
    else if (s1_valid_q && s2_en)     s1_valid_d = 1'b0;

    if (s2_en) out_valid_d = s1_valid_q;

`ifdef SCAZATOR_SAT_EN
    // Clamp toward the sign of the minuend: positive a saturates high, negative a low.
    if (ovf_d) diff_d = s1_ahi_q[7] ? 16'h8000 : 16'h7FFF;
`endif
    zero_d = (diff_d == 16'h0000);
  end

  // Valid flags and output registers, synchronously reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= 16'h0000;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s2_en && s1_valid_q) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  // Stage 1 datapath, loaded on every input transfer.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these bits are only observed while s1_valid_q is set.
    if (in_xfer) begin
      s1_lo_q  <= s1_res.sum;
      s1_c8_q  <= s1_res.c8;
      s1_ahi_q <= a[15:8];
      s1_bhi_q <= b[15:8];
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_scazator_16bit_pipe.sv
// Self-checking bench for scazator_16bit_pipe: directed vectors, backpressure,
// mid-stream reset and a randomized handshake run against an arithmetic model.
// Honours SCAZATOR_SAT_EN the same way the design does.
module tb_scazator_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        bin_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  scazator_16bit_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .bin       (bin_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acc    = 0;
  int          n_pop    = 0;
  logic [18:0] exp_q[$];
  logic        stalled_prev = 1'b0;
  logic [18:0] held;

  // Reference: {diff, bout, ovf, zero} from integer arithmetic on the operands.
  function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin);
    int          ur;
    int          sr;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    ur = int'(ma) - int'(mb) - int'(mbin);
    sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    bo = (ur < 0);
    d  = 16'(ur);
    ov = (sr > 32767) || (sr < -32768);
`ifdef SCAZATOR_SAT_EN
    if (ov) d = (sr > 32767) ? 16'h7FFF : 16'h8000;
`endif
    return {d, bo, ov, (d == 16'h0000)};
  endfunction

  // One clock cycle: drive at negedge, observe transfers and stall stability.
  task automatic do_cycle(input logic ordy, input logic ivld, input logic [15:0] ta,
                          input logic [15:0] tb_v, input logic tbin);
    logic [18:0] e;
    @(negedge clk);
    out_ready = ordy;
    in_valid  = ivld;
    a_s       = ta;
    b_s       = tb_v;
    bin_s     = tbin;
    #1;
    if (stalled_prev) begin
      n_checks++;
      if (out_valid !== 1'b1 || {diff, bout, ovf, zero} !== held)
        $display("FAIL stall_hold: got valid=%b %h/%b%b%b required valid=1 %h/%b%b%b",
                 out_valid, diff, bout, ovf, zero, held[18:3], held[2], held[1], held[0]);
      else n_pass++;
    end
    if (out_valid === 1'b1 && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result: got diff=%h with no operation outstanding", diff);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        if ({diff, bout, ovf, zero} !== e)
          $display("FAIL result: got %h/%b%b%b required %h/%b%b%b",
                   diff, bout, ovf, zero, e[18:3], e[2], e[1], e[0]);
        else n_pass++;
      end
    end
    if (in_valid && in_ready === 1'b1) begin
      exp_q.push_back(model(a_s, b_s, bin_s));
      n_acc++;
    end
    stalled_prev = (out_valid === 1'b1) && !out_ready;
    held         = {diff, bout, ovf, zero};
  endtask

  task automatic idle(input logic ordy);
    do_cycle(ordy, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || out_valid === 1'b1); i++) idle(1'b1);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout: got %0d outstanding required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_s = '0; b_s = '0; bin_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, diff, bout, ovf, zero, in_ready} !== {1'b0, 16'h0000, 3'b000, 1'b1})
      $display("FAIL reset_state: got v=%b d=%h b=%b o=%b z=%b r=%b required v=0 d=0000 b=0 o=0 z=0 r=1",
               out_valid, diff, bout, ovf, zero, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                             input logic [18:0] want);
    int acc0;
    acc0 = n_acc;
    do_cycle(1'b1, 1'b1, ta, tb_v, tbin);
    n_checks++;
    if (n_acc != acc0 + 1) $display("FAIL vec_accept: got in_ready=%b required 1", in_ready);
    else n_pass++;
    idle(1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL vec_latency_early: got out_valid=%b required 0", out_valid);
    else n_pass++;
    idle(1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || {diff, bout, ovf, zero} !== want)
      $display("FAIL vec_%h_%h_%b: got v=%b %h/%b%b%b required v=1 %h/%b%b%b", ta, tb_v, tbin,
               out_valid, diff, bout, ovf, zero, want[18:3], want[2], want[1], want[0]);
    else n_pass++;
    idle(1'b1);
  endtask

  task automatic test_directed();
    test_vector(16'h0005, 16'h0003, 1'b0, {16'h0002, 3'b000});
    test_vector(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b100});
    test_vector(16'h1234, 16'h1233, 1'b1, {16'h0000, 3'b001});
`ifdef SCAZATOR_SAT_EN
    test_vector(16'h8000, 16'h0000, 1'b1, {16'h8000, 3'b010});
    test_vector(16'h7FFF, 16'hFFFF, 1'b0, {16'h7FFF, 3'b110});
`else
    test_vector(16'h8000, 16'h0000, 1'b1, {16'h7FFF, 3'b010});
    test_vector(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 3'b110});
`endif
  endtask

  task automatic test_backpressure();
    int          acc0;
    int          pop0;
    int          sent;
    logic [15:0] ca;
    logic [15:0] cb;
    logic        cbin;
    acc0 = n_acc;
    pop0 = n_pop;
    sent = 0;
    ca = 16'($urandom); cb = 16'($urandom); cbin = 1'($urandom);
    for (int c = 0; c < 5; c++) begin
      do_cycle(1'b0, 1'b1, ca, cb, cbin);
      if (c >= 2) begin
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b required 0 (cycle %0d)", in_ready, c);
        else n_pass++;
      end
      if (n_acc != acc0 + sent) begin
        sent++;
        ca = 16'($urandom); cb = 16'($urandom); cbin = 1'($urandom);
      end
    end
    n_checks++;
    if (sent != 2) $display("FAIL bp_accepts: got %0d required 2", sent);
    else n_pass++;
    for (int c = 0; c < 20 && sent < 6; c++) begin
      do_cycle(1'b1, 1'b1, ca, cb, cbin);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL bp_full_rate: got in_ready=%b required 1", in_ready);
      else n_pass++;
      if (n_acc != acc0 + sent) begin
        sent++;
        ca = 16'($urandom); cb = 16'($urandom); cbin = 1'($urandom);
      end
    end
    drain();
    n_checks++;
    if (n_pop - pop0 != 6) $display("FAIL bp_result_count: got %0d required 6", n_pop - pop0);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    do_cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    do_cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    stalled_prev = 1'b0;
    n_checks++;
    if ({out_valid, diff, in_ready} !== {1'b0, 16'h0000, 1'b1})
      $display("FAIL midreset_state: got v=%b d=%h r=%b required v=0 d=0000 r=1",
               out_valid, diff, in_ready);
    else n_pass++;
    repeat (5) idle(1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midreset_stale: got out_valid=%b required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int pop0;
    int acc0;
    pop0 = n_pop;
    acc0 = n_acc;
    for (int c = 0; c < 200; c++)
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom));
    drain();
    n_checks++;
    if (n_pop - pop0 != n_acc - acc0)
      $display("FAIL random_count: got %0d results required %0d", n_pop - pop0, n_acc - acc0);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
